// File: rtl/dllp_rx_engine.sv
// Two-beat DLLP receiver: CRC-16 check, Ack/Nak decode, per-VC flow-control credits; registered outputs one cycle after the CRC beat, never stalls.
// Define DLLP_RX_CRC_ERR_CNT_EN to build the saturating bad-DLLP counter; otherwise crc_err_cnt_o is tied to zero.
module dllp_rx_engine #(
    parameter int DATA_WIDTH    = 32,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int USER_WIDTH    = 4,
    parameter int NUM_VC        = 1,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     phy_link_up_i,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]    s_axis_tkeep,
    input  logic                     s_axis_tvalid,
    input  logic                     s_axis_tlast,
    input  logic [USER_WIDTH-1:0]    s_axis_tuser,
    output logic                     s_axis_tready,
    output logic [11:0]              seq_num_o,
    output logic                     seq_num_vld_o,
    output logic                     seq_num_acknack_o,
    output logic [8*NUM_VC-1:0]      tx_fc_ph_o,
    output logic [8*NUM_VC-1:0]      tx_fc_nph_o,
    output logic [8*NUM_VC-1:0]      tx_fc_cplh_o,
    output logic [12*NUM_VC-1:0]     tx_fc_pd_o,
    output logic [12*NUM_VC-1:0]     tx_fc_npd_o,
    output logic [12*NUM_VC-1:0]     tx_fc_cpld_o,
    output logic [NUM_VC-1:0]        fc1_values_stored_o,
    output logic [NUM_VC-1:0]        fc2_values_stored_o,
    output logic [NUM_VC-1:0]        update_fc_o,
    output logic [ERR_CNT_WIDTH-1:0] crc_err_cnt_o
);
    typedef enum logic {ST_HDR, ST_CRC} state_t;

    state_t      state;
    logic [31:0] hdr;
    logic [15:0] crc_exp;
    logic [7:0]  ph   [NUM_VC];
    logic [7:0]  nph  [NUM_VC];
    logic [7:0]  cplh [NUM_VC];
    logic [11:0] pd   [NUM_VC];
    logic [11:0] npd  [NUM_VC];
    logic [11:0] cpld [NUM_VC];
    logic [2:0]  fc1  [NUM_VC];
    logic [2:0]  fc2  [NUM_VC];

    // LFSR form of polynomial 100Bh, byte0 bit0 shifted in first; the
    // result is complemented and bit-reversed per byte as it appears on the wire.
    function automatic logic [15:0] pcie_datalink_crc(input logic [31:0] d);
        logic [15:0] c;
        logic [15:0] w;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < 32; i++) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h100B : 16'h0000);
        end
        c = ~c;
        for (int i = 0; i < 8; i++) begin
            w[i]     = c[15-i];
            w[8+i]   = c[7-i];
        end
        return w;
    endfunction

    logic [7:0]  b0, b1, b2, b3;
    logic [1:0]  fc_grp, fc_sel;
    logic [2:0]  vc;
    logic [7:0]  hdr_fc;
    logic [11:0] data_fc;
    logic        hs, dllp_beat, crc_ok, is_ack, is_nak, is_fc;

    assign {b3, b2, b1, b0} = hdr;
    assign fc_grp    = b0[7:6];
    assign fc_sel    = b0[5:4];
    assign vc        = b0[2:0];
    assign hdr_fc    = {b1[5:0], b2[7:6]};
    assign data_fc   = {b2[3:0], b3};
    assign is_ack    = (b0 == 8'h00);
    assign is_nak    = (b0 == 8'h10);
    assign is_fc     = !b0[3] && (fc_sel != 2'd3) && (fc_grp != 2'b00) && (int'(vc) < NUM_VC);
    assign hs        = s_axis_tvalid && s_axis_tready;
    assign dllp_beat = hs && s_axis_tuser[0];
    assign crc_ok    = s_axis_tuser[0] && (s_axis_tdata[15:0] == crc_exp);

    logic unused;
    assign unused = ^{s_axis_tkeep, s_axis_tlast, s_axis_tuser[USER_WIDTH-1:1], b1[7:6], b2[5:4]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state             <= ST_HDR;
            s_axis_tready     <= 1'b0;
            hdr               <= '0;
            crc_exp           <= '0;
            seq_num_o         <= '0;
            seq_num_vld_o     <= 1'b0;
            seq_num_acknack_o <= 1'b0;
            update_fc_o       <= '0;
            for (int v = 0; v < NUM_VC; v++) begin
                ph[v]  <= '0; nph[v] <= '0; cplh[v] <= '0;
                pd[v]  <= '0; npd[v] <= '0; cpld[v] <= '0;
                fc1[v] <= '0; fc2[v] <= '0;
            end
        end else begin
            s_axis_tready <= 1'b1;
            seq_num_vld_o <= 1'b0;
            update_fc_o   <= '0;
            if (!phy_link_up_i) begin
                state <= ST_HDR;
                for (int v = 0; v < NUM_VC; v++) begin
                    fc1[v] <= '0;
                    fc2[v] <= '0;
                end
            end else if (hs) begin
                case (state)
                    ST_HDR: if (dllp_beat) begin
                        hdr     <= s_axis_tdata[31:0];
                        crc_exp <= pcie_datalink_crc(s_axis_tdata[31:0]);
                        state   <= ST_CRC;
                    end
                    default: begin
                        state <= ST_HDR;
                        if (crc_ok) begin
                            if (is_ack || is_nak) begin
                                seq_num_o         <= data_fc;
                                seq_num_acknack_o <= is_ack;
                                seq_num_vld_o     <= 1'b1;
                            end
                            for (int v = 0; v < NUM_VC; v++) begin
                                if (is_fc && int'(vc) == v) begin
                                    case (fc_sel)
                                        2'd0:    begin ph[v]   <= hdr_fc; pd[v]   <= data_fc; end
                                        2'd1:    begin nph[v]  <= hdr_fc; npd[v]  <= data_fc; end
                                        default: begin cplh[v] <= hdr_fc; cpld[v] <= data_fc; end
                                    endcase
                                    case (fc_grp)
                                        2'b01: fc1[v][fc_sel] <= 1'b1;
                                        2'b11: begin
                                            fc2[v][fc_sel] <= 1'b1;
                                            if (fc_sel == 2'd2) update_fc_o[v] <= 1'b1;
                                        end
                                        default: update_fc_o[v] <= 1'b1;
                                    endcase
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        assign tx_fc_ph_o[8*v +: 8]     = ph[v];
        assign tx_fc_nph_o[8*v +: 8]    = nph[v];
        assign tx_fc_cplh_o[8*v +: 8]   = cplh[v];
        assign tx_fc_pd_o[12*v +: 12]   = pd[v];
        assign tx_fc_npd_o[12*v +: 12]  = npd[v];
        assign tx_fc_cpld_o[12*v +: 12] = cpld[v];
        assign fc1_values_stored_o[v]   = &fc1[v];
        assign fc2_values_stored_o[v]   = &fc2[v];
    end

`ifdef DLLP_RX_CRC_ERR_CNT_EN
    logic [ERR_CNT_WIDTH-1:0] err_cnt;
    // A non-DLLP beat in place of the CRC beat counts the same as a CRC miss.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            err_cnt <= '0;
        else if (phy_link_up_i && hs && state == ST_CRC && !crc_ok && err_cnt != '1)
            err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
    end
    assign crc_err_cnt_o = err_cnt;
`else
    assign crc_err_cnt_o = '0;
`endif
endmodule

// File: tb/tb_dllp_rx_engine.sv
// Scoreboard bench for dllp_rx_engine (NUM_VC=2, 4-bit error counter so saturation is reachable quickly).
module tb_dllp_rx_engine;
    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        phy_link_up_i = 1'b1;
    logic [31:0] s_axis_tdata = '0;
    logic [3:0]  s_axis_tkeep = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic [3:0]  s_axis_tuser = '0;
    logic        s_axis_tready;
    logic [11:0] seq_num_o;
    logic        seq_num_vld_o, seq_num_acknack_o;
    logic [15:0] tx_fc_ph_o, tx_fc_nph_o, tx_fc_cplh_o;
    logic [23:0] tx_fc_pd_o, tx_fc_npd_o, tx_fc_cpld_o;
    logic [1:0]  fc1_values_stored_o, fc2_values_stored_o, update_fc_o;
    logic [3:0]  crc_err_cnt_o;

    dllp_rx_engine #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .USER_WIDTH(4), .NUM_VC(2), .ERR_CNT_WIDTH(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .phy_link_up_i(phy_link_up_i),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser), .s_axis_tready(s_axis_tready),
        .seq_num_o(seq_num_o), .seq_num_vld_o(seq_num_vld_o), .seq_num_acknack_o(seq_num_acknack_o),
        .tx_fc_ph_o(tx_fc_ph_o), .tx_fc_nph_o(tx_fc_nph_o), .tx_fc_cplh_o(tx_fc_cplh_o),
        .tx_fc_pd_o(tx_fc_pd_o), .tx_fc_npd_o(tx_fc_npd_o), .tx_fc_cpld_o(tx_fc_cpld_o),
        .fc1_values_stored_o(fc1_values_stored_o), .fc2_values_stored_o(fc2_values_stored_o),
        .update_fc_o(update_fc_o), .crc_err_cnt_o(crc_err_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [11:0] seq; logic ack; int cyc;} ack_t;
    typedef struct packed {logic [1:0] vec; int cyc;} upd_t;

    ack_t        ack_q[$];
    upd_t        upd_q[$];
    ack_t        ae;
    upd_t        ue;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          n_pulses = 0;
    int          n0;
    logic        burst_mon = 1'b0;
    logic        rdy_low = 1'b0;
    logic [7:0]  m_ph[2], m_nph[2], m_cplh[2];
    logic [11:0] m_pd[2], m_npd[2], m_cpld[2];
    logic [2:0]  m_fc1[2], m_fc2[2];
    logic [3:0]  m_err;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reflected (right-shifting) CRC-16, polynomial 100Bh reversed = D008h; complement gives wire order.
    function automatic logic [15:0] tb_crc(input logic [31:0] w);
        logic [15:0] r;
        r = 16'hFFFF;
        for (int k = 0; k < 4; k++) begin
            r = r ^ {8'h00, w[8*k +: 8]};
            for (int j = 0; j < 8; j++) r = r[0] ? ((r >> 1) ^ 16'hD008) : (r >> 1);
        end
        return ~r;
    endfunction

    function automatic logic [3:0] err_exp();
`ifdef DLLP_RX_CRC_ERR_CNT_EN
        return m_err;
`else
        return 4'h0;
`endif
    endfunction

    task automatic model_reset();
        for (int v = 0; v < 2; v++) begin
            m_ph[v] = 0; m_nph[v] = 0; m_cplh[v] = 0;
            m_pd[v] = 0; m_npd[v] = 0; m_cpld[v] = 0;
            m_fc1[v] = 0; m_fc2[v] = 0;
        end
        m_err = 0;
    endtask

    task automatic err_inc();
        if (m_err != 4'hF) m_err = m_err + 4'h1;
    endtask

    task automatic model_commit(input logic [7:0] b0, b1, b2, b3, input int stamp);
        logic [7:0]  hf;
        logic [11:0] df;
        logic [1:0]  pv;
        int          v;
        hf = {b1[5:0], b2[7:6]};
        df = {b2[3:0], b3};
        v  = int'(b0[2:0]);
        if (b0 == 8'h00 || b0 == 8'h10) begin
            ack_q.push_back('{seq: df, ack: (b0 == 8'h00), cyc: stamp});
        end else if (!b0[3] && v < 2) begin
            pv = 2'b00;
            pv[v] = 1'b1;
            case (b0[7:4])
                4'h4, 4'h8, 4'hC: begin m_ph[v] = hf; m_pd[v] = df; end
                4'h5, 4'h9, 4'hD: begin m_nph[v] = hf; m_npd[v] = df; end
                4'h6, 4'hA, 4'hE: begin m_cplh[v] = hf; m_cpld[v] = df; end
                default: ;
            endcase
            case (b0[7:4])
                4'h4: m_fc1[v][0] = 1'b1;
                4'h5: m_fc1[v][1] = 1'b1;
                4'h6: m_fc1[v][2] = 1'b1;
                4'hC: m_fc2[v][0] = 1'b1;
                4'hD: m_fc2[v][1] = 1'b1;
                4'hE: begin m_fc2[v][2] = 1'b1; upd_q.push_back('{vec: pv, cyc: stamp}); end
                4'h8, 4'h9, 4'hA: upd_q.push_back('{vec: pv, cyc: stamp});
                default: ;
            endcase
        end
    endtask

    task automatic drive(input logic [31:0] d, input logic u, input logic vl, input logic l);
        @(posedge clk); #1;
        s_axis_tdata  = d;
        s_axis_tuser  = {3'($urandom), u};
        s_axis_tvalid = vl;
        s_axis_tkeep  = 4'($urandom);
        s_axis_tlast  = 1'($urandom);
        phy_link_up_i = l;
    endtask

    task automatic idle(input int n);
        repeat (n) drive($urandom, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic send(input logic [7:0] b0, b1, b2, b3, input logic bad);
        logic [31:0] w;
        logic [15:0] c;
        w = {b3, b2, b1, b0};
        c = tb_crc(w);
        if (bad) c = c ^ 16'h0100;
        drive(w, 1'b1, 1'b1, 1'b1);
        drive({16'($urandom), c}, 1'b1, 1'b1, 1'b1);
        if (bad) err_inc();
        else model_commit(b0, b1, b2, b3, cyc + 1);
    endtask

    task automatic send_fc(input logic [7:0] b0, input logic [7:0] hf, input logic [11:0] df, input logic bad);
        send(b0, {2'b00, hf[7:2]}, {hf[1:0], 2'b00, df[11:8]}, df[7:0], bad);
    endtask

    task automatic send_ack(input logic ack, input logic [11:0] seq);
        send(ack ? 8'h00 : 8'h10, 8'h00, {4'h0, seq[11:8]}, seq[7:0], 1'b0);
    endtask

    task automatic check_state(input string tag);
        for (int v = 0; v < 2; v++) begin
            chk({tag, "_ph"},   32'(tx_fc_ph_o[8*v +: 8]),    32'(m_ph[v]));
            chk({tag, "_nph"},  32'(tx_fc_nph_o[8*v +: 8]),   32'(m_nph[v]));
            chk({tag, "_cplh"}, 32'(tx_fc_cplh_o[8*v +: 8]),  32'(m_cplh[v]));
            chk({tag, "_pd"},   32'(tx_fc_pd_o[12*v +: 12]),  32'(m_pd[v]));
            chk({tag, "_npd"},  32'(tx_fc_npd_o[12*v +: 12]), 32'(m_npd[v]));
            chk({tag, "_cpld"}, 32'(tx_fc_cpld_o[12*v +: 12]), 32'(m_cpld[v]));
        end
        chk({tag, "_fc1"}, 32'(fc1_values_stored_o), 32'({&m_fc1[1], &m_fc1[0]}));
        chk({tag, "_fc2"}, 32'(fc2_values_stored_o), 32'({&m_fc2[1], &m_fc2[0]}));
        chk({tag, "_err"}, 32'(crc_err_cnt_o), 32'(err_exp()));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_i = 1'b1;
        s_axis_tvalid = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk("rst_tready", 32'(s_axis_tready), 32'd0);
        chk("rst_seq", 32'({seq_num_o, seq_num_vld_o, seq_num_acknack_o}), 32'd0);
        chk("rst_upd", 32'(update_fc_o), 32'd0);
        check_state("rst");
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("tready_after_rst", 32'(s_axis_tready), 32'd1);
    endtask

    always @(negedge clk) begin
        if (burst_mon && !s_axis_tready) rdy_low = 1'b1;
        if (seq_num_vld_o) begin
            n_pulses++;
            if (ack_q.size() == 0) chk("ack_spurious", 32'(seq_num_vld_o), 32'd0);
            else begin
                ae = ack_q.pop_front();
                chk("ack_seq", 32'(seq_num_o), 32'(ae.seq));
                chk("ack_type", 32'(seq_num_acknack_o), 32'(ae.ack));
                chk("ack_cycle", 32'(cyc), 32'(ae.cyc));
            end
        end
        if (update_fc_o != 2'b00) begin
            n_pulses++;
            if (upd_q.size() == 0) chk("upd_spurious", 32'(update_fc_o), 32'd0);
            else begin
                ue = upd_q.pop_front();
                chk("upd_vec", 32'(update_fc_o), 32'(ue.vec));
                chk("upd_cycle", 32'(cyc), 32'(ue.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        do_reset();

        // Header beat of a Nak lost to a reset; the following Ack must decode cleanly.
        drive({8'h23, 8'h01, 8'h00, 8'h10}, 1'b1, 1'b1, 1'b1);
        do_reset();
        send_ack(1'b1, 12'hABC);
        idle(2);
        send_ack(1'b0, 12'h5A5);
        idle(2);

        send_fc(8'h41, 8'h20, 12'h100, 1'b0);
        send_fc(8'h51, 8'h20, 12'h100, 1'b0);
        send_fc(8'h61, 8'h20, 12'h100, 1'b0);
        idle(2);
        check_state("initfc1");

        send_fc(8'hC0, 8'h11, 12'h0AA, 1'b0);
        send_fc(8'hD0, 8'h12, 12'h0BB, 1'b0);
        send_fc(8'hE0, 8'h13, 12'h0CC, 1'b0);
        idle(2);
        check_state("initfc2");
        send_fc(8'h90, 8'h05, 12'h033, 1'b0);
        idle(2);
        check_state("updnp");

        send_fc(8'h80, 8'h7E, 12'hFED, 1'b1);
        idle(2);
        check_state("badcrc");
        drive({8'h00, 8'h00, 8'h00, 8'h80}, 1'b1, 1'b1, 1'b1);
        drive($urandom, 1'b0, 1'b1, 1'b1);
        err_inc();
        send_fc(8'h81, 8'h3C, 12'h456, 1'b0);
        idle(2);
        check_state("tlp_abort");

        // No visible effect: VC beyond NUM_VC, reserved bit3, unknown type.
        send_fc(8'h83, 8'h44, 12'h444, 1'b0);
        send_fc(8'h48, 8'h55, 12'h555, 1'b0);
        send(8'h30, 8'h12, 8'h34, 8'h56, 1'b0);
        idle(2);
        check_state("ignored");

        n0 = n_pulses;
        burst_mon = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) send_ack(i % 4 == 0, 12'($urandom));
            else send_fc((i % 4 == 1) ? 8'h80 : 8'hA1, 8'(i * 3), 12'(i * 17), 1'b0);
        end
        idle(3);
        burst_mon = 1'b0;
        chk("burst_commits", 32'(n_pulses - n0), 32'd10);
        chk("burst_tready_low", 32'(rdy_low), 32'd0);
        check_state("burst");

        // CRC beat arrives in the same cycle the link drops: nothing commits, flags clear.
        drive({8'h00, 8'h00, 8'h1D, 8'h80}, 1'b1, 1'b1, 1'b1);
        drive({16'h0, tb_crc({8'h00, 8'h00, 8'h1D, 8'h80})}, 1'b1, 1'b1, 1'b0);
        for (int v = 0; v < 2; v++) begin m_fc1[v] = 0; m_fc2[v] = 0; end
        drive({8'h00, 8'h00, 8'h1D, 8'h81}, 1'b1, 1'b1, 1'b0);
        drive({16'h0, tb_crc({8'h00, 8'h00, 8'h1D, 8'h81})}, 1'b1, 1'b1, 1'b0);
        drive($urandom, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_state("linkdown");
        idle(1);
        send_ack(1'b1, 12'h00F);
        idle(2);

        repeat (20) begin
            drive({24'($urandom), 8'h90}, 1'b1, 1'b1, 1'b1);
            drive($urandom, 1'b0, 1'b1, 1'b1);
            err_inc();
        end
        idle(2);
        check_state("saturate");

        idle(4);
        chk("ack_pending", 32'(ack_q.size()), 32'd0);
        chk("upd_pending", 32'(upd_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dllp_rx_engine.md
# dllp_rx_engine

Parametrised successor to the single-channel DLLP receive handler in the data link layer. Accepts DLLP beats from the physical-layer AXI-Stream at full rate with no dead cycles, checks the 16-bit DLLP CRC, and decodes Ack/Nak and InitFC1/InitFC2/UpdateFC DLLPs. Flow-control credits are tracked per virtual channel for up to eight VCs. Outputs feed the retry buffer (Ack/Nak) and the transmit credit gate (FC values).

## Interface
- DATA_WIDTH, 32, stream width; only 32 supported.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- USER_WIDTH, 4, tuser width; bit 0 = beat is DLLP.
- NUM_VC, 1, virtual channels decoded, 1..8.
- ERR_CNT_WIDTH, 16, CRC error counter width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock; synchronous, active-high.
- phy_link_up_i  in  1  physical link up.
- s_axis_tdata/tkeep/tvalid/tlast/tuser  in  32/KEEP_WIDTH/1/1/USER_WIDTH  DLLP stream.
- s_axis_tready  out  1  always 1 out of reset.
- seq_num_o  out  12  Ack/Nak sequence number.
- seq_num_vld_o  out  1  one-cycle pulse.
- seq_num_acknack_o  out  1  1 = Ack, 0 = Nak; qualified by vld.
- tx_fc_ph_o, tx_fc_nph_o, tx_fc_cplh_o  out  8*NUM_VC  header credits; VC n at [8n+:8].
- tx_fc_pd_o, tx_fc_npd_o, tx_fc_cpld_o  out  12*NUM_VC  data credits; VC n at [12n+:12].
- fc1_values_stored_o, fc2_values_stored_o  out  NUM_VC  all three InitFC1 (InitFC2) types seen for the VC.
- update_fc_o  out  NUM_VC  one-cycle pulse per VC on credit update.
- crc_err_cnt_o  out  ERR_CNT_WIDTH  saturating bad-DLLP count.

## Operation
- A DLLP is two beats, both with tuser[0]=1.
  - Beat 0: byte k in tdata[8k+:8]; byte0 = type.
  - Beat 1: tdata[15:0] = CRC.
- Beats with tuser[0]=0 are consumed and ignored. tkeep and tlast are ignored.
- FSM:
  - ST_HDR: DLLP beat → latch beat 0, compute CRC (pcie_datalink_crc, seed 16'hFFFF), go to ST_CRC.
  - ST_CRC: DLLP beat → compare with per-byte bit-reversed CRC, then return to ST_HDR. Match commits the DLLP; mismatch discards it and increments the error count.
  - ST_CRC: non-DLLP beat → discard the held header, count an error, go to ST_HDR.
- Type decode (byte0):
  - Ack = 8'h00; Nak = 8'h10.
  - InitFC1 P/NP/Cpl = 8'h4v/8'h5v/8'h6v.
  - InitFC2 = 8'hCv/8'hDv/8'hEv.
  - UpdateFC = 8'h8v/8'h9v/8'hAv.
  - v = byte0[2:0] is the VC; byte0[3] must be 0.
- Field extraction:
  - Ack/Nak seq = {byte2[3:0], byte3}.
  - HdrFC = {byte1[5:0], byte2[7:6]}.
  - DataFC = {byte2[3:0], byte3}.
- On a committed FC DLLP, the addressed VC's header/data registers load HdrFC/DataFC.
  - InitFC1: sets the per-type fc1 flag.
  - InitFC2: sets the per-type fc2 flag.
  - InitFC2_Cpl and all UpdateFC pulse update_fc_o[v].
- v ≥ NUM_VC, unknown types and PM/vendor DLLPs: CRC is still checked; there is no other effect.
- phy_link_up_i=0:
  - Beats are consumed and dropped; FSM forced to ST_HDR.
  - All fc1/fc2 flags clear; credit registers hold.
- Error counter saturates at all-ones.

## Timing
- Throughput: one DLLP per two cycles, back-to-back, no stall.
- Latency: seq_num_*, credits and update_fc_o are registered. They change or pulse the cycle after the CRC beat handshake.
- Simultaneous events: a commit and a link-down in the same cycle: link-down wins, nothing commits.
- Reset values: all outputs 0; s_axis_tready 0 during reset, 1 from the first cycle after.
- Reset mid-DLLP: the held header is lost; the next DLLP beat is treated as beat 0.

## Configuration
- DLLP_RX_CRC_ERR_CNT_EN defined: crc_err_cnt_o counts as above.
- Undefined: counter logic is removed and crc_err_cnt_o is tied to 0; CRC-fail discard behaviour is unchanged.

## Test plan
- Ack DLLP with seq 12'hABC and good CRC → seq_num_o=12'hABC, acknack=1, vld pulse exactly one cycle, two cycles after beat 0.
- NUM_VC=2: InitFC1_P/NP/Cpl on VC1 with HdrFC=8'h20, DataFC=12'h100 → fc1_values_stored_o=2'b10; VC1 credit slices = 8'h20/12'h100; VC0 slices unchanged.
- InitFC2_Cpl on VC0 → fc2 flag set, update_fc_o=2'b01 for one cycle; UpdateFC_NP with HdrFC=8'h05 → tx_fc_nph_o[7:0]=8'h05 and a pulse.
- Corrupted CRC on UpdateFC_P → credits unchanged, no pulse, crc_err_cnt_o +1; a header followed by a TLP beat → error +1, and the next good DLLP decodes.
- Back-to-back DLLPs with tvalid held high for 20 cycles → 10 commits, tready never low.
- Link drop after stored flags are set → flags go to 0, credits hold; error counter saturates at 16'hFFFF when forced.
